multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle MIPS control FSM. Sequences the shared datapath (PC, IR, register file, ALU, unified memory) over FETCH/DECODE/EXEC/MEM/WB steps.
//  Instruction set: R-type, addi, sltiu, ori, lui, beq, bne, lw, sw, j, jal.
//  Sits between the IR opcode field and the datapath muxes/enables. Replaces single-cycle opcode decoding for the multi-cycle core.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles to wait for mem_ready_i in a memory state before bus_err_o
//  CNT_W        32  width of retired-instruction counter
// PORTS
//  clk_i         in   1      clock; all state updates on rising edge
//  rst_i         in   1      reset, asynchronous, active-high
//  instr_op_i    in   6      IR[31:26]; valid from DECODE onward
//  zero_i        in   1      ALU zero flag (rs-rt compare in BRANCH)
//  mem_ready_i   in   1      memory completes current read/write this cycle
//  pc_write_o    out  1      load PC
//  ir_write_o    out  1      load IR from memory data
//  iord_o        out  1      mem addr: 0=PC, 1=ALUOut
//  mem_read_o    out  1      memory read strobe
//  mem_write_o   out  1      memory write strobe
//  reg_write_o   out  1      register-file write enable
//  reg_dst_o     out  2      0=rt, 1=rd, 2=$31
//  mem_to_reg_o  out  2      0=ALUOut, 1=MDR, 2=PC (link)
//  alu_src_a_o   out  1      0=PC, 1=rs
//  alu_src_b_o   out  2      0=rt, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
//  alu_op_o      out  4      same encoding as single-cycle decoder: R_TYPE=0, ADDI=1, SLTIU=2, BEQ=3, LUI=4, ORI=5, BNE=6, LW=7, SW=8, J=12, JAL=13
//  pc_src_o      out  2      0=ALU result, 1=ALUOut (branch target), 2=jump target
//  illegal_o     out  1      1-cycle pulse: unknown opcode in DECODE
//  bus_err_o     out  1      1-cycle pulse: memory timeout
//  instr_cnt_o   out  CNT_W  retired-instruction count
// BEHAVIOUR
//  - Reset (asynchronous): state=FETCH, wait counter=0, instr_cnt_o=0. While rst_i=1, every strobe/enable output=0 and every select output=0.
//  - Outputs: Moore, decoded from the registered state only.
//    Exceptions: pc_write_o in BRANCH depends on zero_i; pc_write_o/ir_write_o in FETCH are gated by mem_ready_i.
//  - FETCH: mem_read=1, iord=0, src_a=0, src_b=1, alu_op=ADDI, pc_src=0.
//    Hold until mem_ready_i; in that cycle ir_write=1, pc_write=1 (PC+4). Then go to DECODE.
//  - DECODE: src_a=0, src_b=3, alu_op=ADDI (branch target into ALUOut). Next state by opcode:
//    lw/sw->MEM_ADDR; R->EXEC_R; addi/sltiu/ori/lui->EXEC_I; beq/bne->BRANCH; j/jal->JUMP; other->FETCH with illegal_o=1.
//  - MEM_ADDR: src_a=1, src_b=2, alu_op=LW|SW. Next: lw->MEM_RD, sw->MEM_WR.
//  - MEM_RD: mem_read=1, iord=1; hold until mem_ready_i, then MEM_WB.
//  - MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1. Then FETCH.
//  - MEM_WR: mem_write=1, iord=1; hold until mem_ready_i, then FETCH.
//  - EXEC_R: src_a=1, src_b=0, alu_op=R_TYPE, then R_WB (reg_write=1, reg_dst=1, mem_to_reg=0).
//  - EXEC_I: src_a=1, src_b=2, alu_op per opcode, then I_WB (reg_write=1, reg_dst=0, mem_to_reg=0).
//  - BRANCH: src_a=1, src_b=0, alu_op=BEQ|BNE, pc_src=1.
//    pc_write=zero_i for beq, =!zero_i for bne. Then FETCH.
//  - JUMP: pc_write=1, pc_src=2. jal also drives reg_write=1, reg_dst=2, mem_to_reg=2 (PC already +4). Then FETCH.
//  - Memory handshake: strobe held constant across wait cycles.
//    Wait counter increments each non-ready cycle in FETCH/MEM_RD/MEM_WR and clears on state exit.
//    On reaching MEM_TIMEOUT without ready: bus_err_o=1 for 1 cycle, abort to FETCH, no write, counter cleared.
//  - instr_cnt_o increments on entry to FETCH from MEM_WB, MEM_WR (ready), R_WB, I_WB, BRANCH, JUMP. Wraps modulo 2^CNT_W.
//    Does not increment on illegal or bus_err aborts.
//  - Latency in cycles with zero memory wait: R/I-type 4, lw 5, sw 4, beq/bne 3, j/jal 3.
//  - Async reset mid-instruction: abandons the instruction immediately. No partial register write or PC write after reset asserts.
// STRUCTURE
//  - Shared include cpu_defs.vh: opcode constants, ALU-op localparams (shared with single-cycle decoder), state encoding (4-bit), mux-select constants.
//  - One natural sub-module: mc_out_rom. Combinational state+opcode -> control word; no logic beyond table lookup.
//  - FSM register, wait counter and instr counter stay in the top.
// TESTING
//  - Reset released, mem_ready_i=1, IR op=000000: states FETCH,DECODE,EXEC_R,R_WB,FETCH; reg_write=1 only in cycle 4 with reg_dst=1; instr_cnt=1.
//  - lw (100011), mem_ready_i low 3 cycles in MEM_RD: mem_read/iord held 4 cycles; MEM_WB on 5th; total 8 cycles; bus_err_o=0.
//  - beq with zero_i=1 -> pc_write=1, pc_src=1 in BRANCH; bne with zero_i=1 -> pc_write=0; both retire (cnt +1 each).
//  - jal (000011): JUMP asserts pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2; next state FETCH.
//  - mem_ready_i stuck 0 in FETCH: bus_err_o pulses after 16 wait cycles; FETCH re-entered; ir_write never 1; instr_cnt unchanged.
//  - Op 111111 -> illegal_o pulse in DECODE, back to FETCH. rst_i asserted mid-MEM_WR -> mem_write_o drops same cycle, state=FETCH, counters=0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: opcodes, ALU ops, states, control word.
// Pure declarations and decode helpers; no timing or flow control of its own.
package multicycle_ctrl_pkg;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // ALU op encoding is shared with the single-cycle decoder
    localparam logic [3:0] ALU_R_TYPE = 4'd0;
    localparam logic [3:0] ALU_ADDI   = 4'd1;
    localparam logic [3:0] ALU_SLTIU  = 4'd2;
    localparam logic [3:0] ALU_BEQ    = 4'd3;
    localparam logic [3:0] ALU_LUI    = 4'd4;
    localparam logic [3:0] ALU_ORI    = 4'd5;
    localparam logic [3:0] ALU_BNE    = 4'd6;
    localparam logic [3:0] ALU_LW     = 4'd7;
    localparam logic [3:0] ALU_SW     = 4'd8;
    localparam logic [3:0] ALU_J      = 4'd12;
    localparam logic [3:0] ALU_JAL    = 4'd13;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_EXEC_R, S_R_WB, S_EXEC_I, S_I_WB, S_BRANCH, S_JUMP
    } state_e;

    typedef enum logic [2:0] {
        PCW_NONE, PCW_ALWAYS, PCW_READY, PCW_ZERO, PCW_NZERO
    } pcw_e;

    typedef struct packed {
        pcw_e       pcw;
        logic       ir_wr_rdy;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    function automatic state_e decode_next(input logic [5:0] op);
        case (op)
            OP_LW, OP_SW:                       return S_MEM_ADDR;
            OP_R:                               return S_EXEC_R;
            OP_ADDI, OP_SLTIU, OP_ORI, OP_LUI:  return S_EXEC_I;
            OP_BEQ, OP_BNE:                     return S_BRANCH;
            OP_J, OP_JAL:                       return S_JUMP;
            default:                            return S_FETCH;
        endcase
    endfunction

    function automatic logic op_legal(input logic [5:0] op);
        return (decode_next(op) != S_FETCH);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_out.sv
// Control-word table: state + opcode -> datapath selects/strobes. Purely combinational.
// Zero latency; stalls are handled by the FSM, the table only flags which enables wait on ready/zero.
module mc_out_rom
    import multicycle_ctrl_pkg::*;
(
    input  state_e       state_i,
    input  logic [5:0]   op_i,
    output ctrl_t        ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = 2'd1;
                ctrl_o.alu_op    = ALU_ADDI;
                ctrl_o.pcw       = PCW_READY;
                ctrl_o.ir_wr_rdy = 1'b1;
            end
            S_DECODE: begin
                ctrl_o.alu_src_b = 2'd3;
                ctrl_o.alu_op    = ALU_ADDI;
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = 2'd2;
                ctrl_o.alu_op    = (op_i == OP_SW) ? ALU_SW : ALU_LW;
            end
            S_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 2'd1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.iord      = 1'b1;
            end
            S_EXEC_R: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALU_R_TYPE;
            end
            S_R_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 2'd1;
            end
            S_EXEC_I: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = 2'd2;
                case (op_i)
                    OP_SLTIU: ctrl_o.alu_op = ALU_SLTIU;
                    OP_ORI:   ctrl_o.alu_op = ALU_ORI;
                    OP_LUI:   ctrl_o.alu_op = ALU_LUI;
                    default:  ctrl_o.alu_op = ALU_ADDI;
                endcase
            end
            S_I_WB: begin
                ctrl_o.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.pc_src    = 2'd1;
                ctrl_o.alu_op    = (op_i == OP_BNE) ? ALU_BNE : ALU_BEQ;
                ctrl_o.pcw       = (op_i == OP_BNE) ? PCW_NZERO : PCW_ZERO;
            end
            S_JUMP: begin
                ctrl_o.pcw    = PCW_ALWAYS;
                ctrl_o.pc_src = 2'd2;
                if (op_i == OP_JAL) begin
                    ctrl_o.reg_write  = 1'b1;
                    ctrl_o.reg_dst    = 2'd2;
                    ctrl_o.mem_to_reg = 2'd2;
                end
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: state register, memory wait/timeout counter, retired-instruction count.
// 3-5 cycles per instruction plus memory wait cycles; a memory state stalls on mem_ready_i up to MEM_TIMEOUT.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       instr_op_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             pc_write_o,
    output logic             ir_write_o,
    output logic             iord_o,
    output logic             mem_read_o,
    output logic             mem_write_o,
    output logic             reg_write_o,
    output logic [1:0]       reg_dst_o,
    output logic [1:0]       mem_to_reg_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [3:0]       alu_op_o,
    output logic [1:0]       pc_src_o,
    output logic             illegal_o,
    output logic             bus_err_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    ctrl_t              ctrl;
    logic               mem_state, timeout, illegal, retire, pcw;

    mc_out_rom u_rom (
        .state_i (state_q),
        .op_i    (instr_op_i),
        .ctrl_o  (ctrl)
    );

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign timeout   = mem_state && !mem_ready_i && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
    assign illegal   = (state_q == S_DECODE) && !op_legal(instr_op_i);

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:    if (mem_ready_i) state_d = S_DECODE;
            S_DECODE:   state_d = decode_next(instr_op_i);
            S_MEM_ADDR: state_d = (instr_op_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready_i) state_d = S_MEM_WB;
            S_MEM_WR:   if (mem_ready_i) begin state_d = S_FETCH; retire = 1'b1; end
            S_EXEC_R:   state_d = S_R_WB;
            S_EXEC_I:   state_d = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:    state_d = S_FETCH;
        endcase
        // A timeout cycle is by definition not ready, so retire is already 0 here
        if (timeout) state_d = S_FETCH;
        wait_d = (mem_state && !mem_ready_i && !timeout) ? wait_q + WAIT_W'(1) : '0;
        cnt_d  = retire ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        case (ctrl.pcw)
            PCW_ALWAYS: pcw = 1'b1;
            PCW_READY:  pcw = mem_ready_i;
            PCW_ZERO:   pcw = zero_i;
            PCW_NZERO:  pcw = !zero_i;
            default:    pcw = 1'b0;
        endcase
    end

    // Everything is forced low while reset is held so an abandoned instruction writes nothing
    assign pc_write_o   = !rst_i && pcw;
    assign ir_write_o   = !rst_i && ctrl.ir_wr_rdy && mem_ready_i;
    assign iord_o       = !rst_i && ctrl.iord;
    assign mem_read_o   = !rst_i && ctrl.mem_read;
    assign mem_write_o  = !rst_i && ctrl.mem_write;
    assign reg_write_o  = !rst_i && ctrl.reg_write;
    assign reg_dst_o    = rst_i ? 2'd0 : ctrl.reg_dst;
    assign mem_to_reg_o = rst_i ? 2'd0 : ctrl.mem_to_reg;
    assign alu_src_a_o  = !rst_i && ctrl.alu_src_a;
    assign alu_src_b_o  = rst_i ? 2'd0 : ctrl.alu_src_b;
    assign alu_op_o     = rst_i ? 4'd0 : ctrl.alu_op;
    assign pc_src_o     = rst_i ? 2'd0 : ctrl.pc_src;
    assign illegal_o    = !rst_i && illegal;
    assign bus_err_o    = !rst_i && timeout;
    assign instr_cnt_o  = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction cycle model built from the instruction step tables.
module tb_multicycle_ctrl;

    localparam int TMO = 16;

    typedef struct packed {
        logic       pcw, irw, iord, mrd, mwr, rw;
        logic [1:0] rdst, m2r;
        logic       sa;
        logic [1:0] sb;
        logic [3:0] aop;
        logic [1:0] psrc;
        logic       ill, berr;
    } outv_t;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [5:0]  instr_op_i;
    logic        zero_i;
    logic        mem_ready_i;
    logic        pc_write_o, ir_write_o, iord_o, mem_read_o, mem_write_o, reg_write_o;
    logic [1:0]  reg_dst_o, mem_to_reg_o, alu_src_b_o, pc_src_o;
    logic        alu_src_a_o, illegal_o, bus_err_o;
    logic [3:0]  alu_op_o;
    logic [31:0] instr_cnt_o;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = '0;
    outv_t       exp_q[$];
    int          rdy_q[$];
    logic [5:0]  ops [12] = '{6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000101, 6'b001000,
                              6'b001011, 6'b001101, 6'b001111, 6'b100011, 6'b101011, 6'b111111};

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk_i(clk), .rst_i(rst_i), .instr_op_i(instr_op_i), .zero_i(zero_i),
        .mem_ready_i(mem_ready_i), .pc_write_o(pc_write_o), .ir_write_o(ir_write_o),
        .iord_o(iord_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o),
        .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
        .pc_src_o(pc_src_o), .illegal_o(illegal_o), .bus_err_o(bus_err_o),
        .instr_cnt_o(instr_cnt_o)
    );

    function automatic outv_t sample();
        outv_t o;
        o = '{pc_write_o, ir_write_o, iord_o, mem_read_o, mem_write_o, reg_write_o,
              reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o, pc_src_o,
              illegal_o, bus_err_o};
        return o;
    endfunction

    function automatic outv_t fetch_v();
        outv_t o = '0;
        o.mrd = 1'b1; o.sb = 2'd1; o.aop = 4'd1;
        return o;
    endfunction

    // ready: 0/1 driven as given, 2 = don't-care cycle driven randomly
    task automatic push(input outv_t o, input int ready);
        exp_q.push_back(o);
        rdy_q.push_back(ready);
    endtask

    // Memory phase with `w` not-ready cycles; returns 0 if it aborted on timeout
    task automatic mem_phase(input outv_t base, input int w, output bit done);
        outv_t o;
        done = 1'b0;
        for (int i = 0; i < w && i < TMO; i++) begin
            o = base;
            o.berr = (i == TMO - 1);
            push(o, 0);
        end
        if (w >= TMO) return;
        o = base;
        if (base.mrd && !base.iord) begin o.irw = 1'b1; o.pcw = 1'b1; end
        push(o, 1);
        done = 1'b1;
    endtask

    task automatic model_instr(input logic [5:0] op, input logic z, input int wf, input int wm,
                               output bit retires);
        outv_t o;
        bit    done;
        bit    legal;
        retires = 1'b0;
        mem_phase(fetch_v(), wf, done);
        if (!done) return;
        legal = 1'b0;
        foreach (ops[i]) if (ops[i] == op && op != 6'b111111) legal = 1'b1;
        o = '0; o.sb = 2'd3; o.aop = 4'd1; o.ill = !legal;
        push(o, 2);
        if (!legal) return;
        o = '0;
        case (op)
            6'b100011, 6'b101011: begin
                o.sa = 1'b1; o.sb = 2'd2; o.aop = (op == 6'b100011) ? 4'd7 : 4'd8;
                push(o, 2);
                o = '0; o.iord = 1'b1;
                if (op == 6'b100011) o.mrd = 1'b1; else o.mwr = 1'b1;
                mem_phase(o, wm, done);
                if (!done) return;
                if (op == 6'b100011) begin
                    o = '0; o.rw = 1'b1; o.m2r = 2'd1;
                    push(o, 2);
                end
            end
            6'b000000: begin
                o.sa = 1'b1; push(o, 2);
                o = '0; o.rw = 1'b1; o.rdst = 2'd1; push(o, 2);
            end
            6'b000100, 6'b000101: begin
                o.sa = 1'b1; o.psrc = 2'd1;
                o.aop = (op == 6'b000101) ? 4'd6 : 4'd3;
                o.pcw = (op == 6'b000101) ? !z : z;
                push(o, 2);
            end
            6'b000010, 6'b000011: begin
                o.pcw = 1'b1; o.psrc = 2'd2;
                if (op == 6'b000011) begin o.rw = 1'b1; o.rdst = 2'd2; o.m2r = 2'd2; end
                push(o, 2);
            end
            default: begin
                o.sa = 1'b1; o.sb = 2'd2;
                case (op)
                    6'b001011: o.aop = 4'd2;
                    6'b001101: o.aop = 4'd5;
                    6'b001111: o.aop = 4'd4;
                    default:   o.aop = 4'd1;
                endcase
                push(o, 2);
                o = '0; o.rw = 1'b1; push(o, 2);
            end
        endcase
        retires = 1'b1;
    endtask

    task automatic run_steps(input int n, input logic [5:0] op);
        outv_t e, got;
        int    r;
        for (int k = 0; k < n; k++) begin
            e = exp_q.pop_front();
            r = rdy_q.pop_front();
            mem_ready_i = (r == 2) ? 1'($urandom_range(0, 1)) : 1'(r);
            @(negedge clk);
            got = sample();
            checks++;
            assert (got === e) else begin
                errors++;
                $error("FAIL ctl op=%b step=%0d got=%h want=%h", op, k, got, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic z, input int wf, input int wm);
        bit ret;
        instr_op_i = op;
        zero_i     = z;
        model_instr(op, z, wf, wm, ret);
        run_steps(exp_q.size(), op);
        if (ret) exp_cnt = exp_cnt + 32'd1;
        checks++;
        assert (instr_cnt_o === exp_cnt) else begin
            errors++;
            $error("FAIL instr_cnt op=%b got=%0d want=%0d", op, instr_cnt_o, exp_cnt);
        end
    endtask

    function automatic int rand_wait();
        return ($urandom_range(0, 19) == 0) ? TMO + 2 : int'($urandom_range(0, 3));
    endfunction

    initial begin
        bit dummy;
        rst_i = 1'b1; instr_op_i = '0; zero_i = 1'b0; mem_ready_i = 1'b1;
        #12;
        checks++;
        assert (sample() === outv_t'(0)) else begin
            errors++;
            $error("FAIL reset_outputs got=%h want=0", sample());
        end
        checks++;
        assert (instr_cnt_o === 32'd0) else begin
            errors++;
            $error("FAIL reset_cnt got=%0d want=0", instr_cnt_o);
        end
        @(posedge clk); #1;
        rst_i = 1'b0;

        run_instr(6'b000000, 1'b0, 0, 0);   // R-type, count becomes 1
        run_instr(6'b100011, 1'b0, 0, 3);   // lw, 3 wait cycles in MEM_RD
        run_instr(6'b000100, 1'b1, 0, 0);   // beq taken
        run_instr(6'b000101, 1'b1, 0, 0);   // bne not taken
        run_instr(6'b000011, 1'b0, 0, 0);   // jal
        run_instr(6'b101011, 1'b0, 2, 1);   // sw
        run_instr(6'b000000, 1'b0, TMO, 0); // fetch timeout
        run_instr(6'b111111, 1'b0, 0, 0);   // illegal
        run_instr(6'b100011, 1'b0, 0, TMO); // MEM_RD timeout
        run_instr(6'b101011, 1'b0, 0, TMO); // MEM_WR timeout

        for (int n = 0; n < 80; n++)
            run_instr(ops[$urandom_range(0, 11)], 1'($urandom_range(0, 1)), rand_wait(), rand_wait());

        // Reset landing in the middle of a stalled store
        instr_op_i = 6'b101011;
        model_instr(6'b101011, 1'b0, 0, 5, dummy);
        run_steps(4, instr_op_i);
        exp_q.delete();
        rdy_q.delete();
        mem_ready_i = 1'b0;
        @(negedge clk);
        checks++;
        assert (mem_write_o === 1'b1) else begin
            errors++;
            $error("FAIL mem_wr_stall got=%b want=1", mem_write_o);
        end
        #2 rst_i = 1'b1;
        #1;
        checks++;
        assert (sample() === outv_t'(0)) else begin
            errors++;
            $error("FAIL midrst_outputs got=%h want=0", sample());
        end
        checks++;
        assert (instr_cnt_o === 32'd0) else begin
            errors++;
            $error("FAIL midrst_cnt got=%0d want=0", instr_cnt_o);
        end
        exp_cnt = '0;
        @(posedge clk); #1;
        rst_i = 1'b0;
        run_instr(6'b001101, 1'b0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
